pipe_ctrl_regs: RTL and testbench
=================================

# pipe_ctrl_regs

Pipeline register bank feeding the hazard unit and obeying its stall/flush commands. Holds the fetch PC, the IF/ID instruction register, and the register-address/control fields of the E, M and W stages. Its outputs are exactly the address/control inputs the hazard unit compares, and its enables are the hazard unit's stallF/stallD/flushE. Also counts stall and branch-flush cycles for performance debug.

## Interface
- XLEN, 64, PC/datapath width
- RESET_PC, 0, PC value loaded by reset
- CNT_W, 32, width of performance counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stallF, stallD, flushE  in  1 each  hazard commands
- pc_srcD  in  1  branch taken, resolved in decode
- pc_branchD  in  XLEN  branch target
- instrF  in  32  instruction-memory read data for pcF
- reg_writeD, mem_to_regD, mem_writeD  in  1 each  decode control
- pcF  out  XLEN  fetch PC
- instrD, pcD  out  32 / XLEN  IF/ID contents
- rs1D, rs2D, rdD  out  5 each  instrD[19:15], [24:20], [11:7], combinational
- rs1E, rs2E, rdE, reg_writeE, mem_to_regE, mem_writeE  out  5/5/5/1/1/1  ID/EX
- write_regM, reg_writeM, mem_to_regM, mem_writeM  out  5/1/1/1  EX/MEM
- write_regW, reg_writeW, mem_to_regW  out  5/1/1  MEM/WB
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- PC: stallF → hold; else pc_srcD → pc_branchD; else pcF+4 (mod 2^XLEN, wraps).
- IF/ID: stallD → hold; else pc_srcD → instrD=NOP (32'h00000013), pcD=0; else instrD=instrF, pcD=pcF.
- Stall beats branch: pc_srcD with stallF/stallD set is ignored that cycle (operands not ready, target invalid); hazard unit reasserts next cycle.
- ID/EX: flushE → rs1E=rs2E=rdE=0, all E control 0 (bubble); else load D fields/controls. No E-stage stall.
- EX/MEM, MEM/WB: advance every cycle unconditionally.
- Bubble invariant: a bubble never writes, never reads memory, and zero addresses never trigger forwarding.
- stall_cnt: +1 each cycle stallD=1; flush_cnt: +1 each cycle pc_srcD=1 and stallD=0. Both saturate at all-ones, no wrap.

## Timing
- Reset (sync): pcF=RESET_PC; instrD=NOP; pcD=0; all E/M/W addresses and controls 0; counters 0. Reset overrides stall/flush.
- Reset asserted mid-operation clears everything on that edge; first fetch from RESET_PC on the first edge after release.
- One cycle per stage: D field visible at E after 1 edge, at M after 2, at W after 3.
- flushE and stallD together (load-use): IF/ID holds, E gets bubble, M/W advance; instruction in D re-enters E one edge after stall drops.
- rs1D/rs2D/rdD change only when instrD changes; no combinational path from stall inputs to any output.

## Structure
- Shared package: NOP encoding, rs1/rs2/rd bit positions, RESET_PC default.
- One sub-module, pipe_reg: WIDTH parameter, sync reset value, enable and sync clear (clear beats enable, reset beats both). Instantiated per stage; counters inline.

## Test plan
- Reset: hold reset 2 cycles with stallF=1, flushE=1 → pcF=0, instrD=32'h00000013, rdE=0, counters 0; after release pcF steps 0,4,8.
- Load-use: instrD with rd=5 in E (mem_to_regE=1), stallF=stallD=flushE=1 for one cycle → pcF and instrD hold, E shows bubble (rdE=0, reg_writeE=0), stall_cnt=1.
- Taken branch: pc_srcD=1, pc_branchD=0x100, no stall → next pcF=0x100, instrD=NOP, flush_cnt=1.
- Branch during stall: pc_srcD=1 with stallF=stallD=1 → pcF holds, instrD holds, flush_cnt unchanged.
- Propagation: reg_writeD=1, rdD=7 with no hazards → rdE=7 after 1 edge, write_regM=7 after 2, write_regW=7 and reg_writeW=1 after 3.
- Saturation/wrap: CNT_W=4, stallD=1 for 20 cycles → stall_cnt stops at 15; pcF at 2^XLEN−4 with no stall/branch → next pcF=0.

Source files
------------

// File: rtl/pipe_ctrl_regs_pkg.sv
// pipe_ctrl_regs_pkg: shared encodings and field positions for the pipeline control register bank
package pipe_ctrl_regs_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB = 7;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// pipe_ctrl_regs_if: hazard commands and decode controls in, stage address/control fields out
interface pipe_ctrl_regs_if #(
    parameter int XLEN = 64,
    parameter int CNT_W = 32
);
    logic stallF, stallD, flushE, pc_srcD;
    logic [XLEN-1:0] pc_branchD;
    logic [31:0] instrF;
    logic reg_writeD, mem_to_regD, mem_writeD;
    logic [XLEN-1:0] pcF, pcD;
    logic [31:0] instrD;
    logic [4:0] rs1D, rs2D, rdD;
    logic [4:0] rs1E, rs2E, rdE;
    logic reg_writeE, mem_to_regE, mem_writeE;
    logic [4:0] write_regM;
    logic reg_writeM, mem_to_regM, mem_writeM;
    logic [4:0] write_regW;
    logic reg_writeW, mem_to_regW;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport slave (
        input stallF, stallD, flushE, pc_srcD, pc_branchD, instrF, reg_writeD, mem_to_regD, mem_writeD,
        output pcF, pcD, instrD, rs1D, rs2D, rdD, rs1E, rs2E, rdE, reg_writeE, mem_to_regE, mem_writeE,
        output write_regM, reg_writeM, mem_to_regM, mem_writeM, write_regW, reg_writeW, mem_to_regW,
        output stall_cnt, flush_cnt
    );
    modport master (
        output stallF, stallD, flushE, pc_srcD, pc_branchD, instrF, reg_writeD, mem_to_regD, mem_writeD,
        input pcF, pcD, instrD, rs1D, rs2D, rdD, rs1E, rs2E, rdE, reg_writeE, mem_to_regE, mem_writeE,
        input write_regM, reg_writeM, mem_to_regM, mem_writeM, write_regW, reg_writeW, mem_to_regW,
        input stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_regs_pipe_reg.sv
// pipe_reg: pipeline register with sync reset, sync clear and enable (reset > clear > enable)
module pipe_reg #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = RST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) data_q <= RST_VAL;
        else if (clr_i) data_q <= CLR_VAL;
        else if (en_i) data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_ctrl_regs.sv
// pipe_ctrl_regs: fetch PC, IF/ID and E/M/W address/control registers driven by hazard-unit commands
module pipe_ctrl_regs
    import pipe_ctrl_regs_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    pipe_ctrl_regs_if.slave bus
);
    logic take;
    logic [XLEN-1:0] pc_d;
    logic [32+XLEN-1:0] ifid_q;
    logic [17:0] e_q;
    logic [7:0] m_q;
    logic [6:0] w_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // A branch seen while either front stage is stalled has an unreliable target; drop it.
    assign take = bus.pc_srcD & ~bus.stallF & ~bus.stallD;
    assign pc_d = take ? bus.pc_branchD : bus.pcF + XLEN'(4);

    pipe_reg #(.WIDTH(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(reset), .en_i(~bus.stallF), .clr_i(1'b0), .d_i(pc_d), .q_o(bus.pcF)
    );

    pipe_reg #(.WIDTH(32 + XLEN), .RST_VAL({NOP, {XLEN{1'b0}}})) u_ifid (
        .clk(clk), .rst(reset), .en_i(~bus.stallD), .clr_i(take),
        .d_i({bus.instrF, bus.pcF}), .q_o(ifid_q)
    );

    assign {bus.instrD, bus.pcD} = ifid_q;
    assign bus.rs1D = bus.instrD[RS1_LSB +: 5];
    assign bus.rs2D = bus.instrD[RS2_LSB +: 5];
    assign bus.rdD = bus.instrD[RD_LSB +: 5];

    pipe_reg #(.WIDTH(18)) u_idex (
        .clk(clk), .rst(reset), .en_i(1'b1), .clr_i(bus.flushE),
        .d_i({bus.rs1D, bus.rs2D, bus.rdD, bus.reg_writeD, bus.mem_to_regD, bus.mem_writeD}),
        .q_o(e_q)
    );

    assign {bus.rs1E, bus.rs2E, bus.rdE, bus.reg_writeE, bus.mem_to_regE, bus.mem_writeE} = e_q;

    pipe_reg #(.WIDTH(8)) u_exmem (
        .clk(clk), .rst(reset), .en_i(1'b1), .clr_i(1'b0),
        .d_i({bus.rdE, bus.reg_writeE, bus.mem_to_regE, bus.mem_writeE}), .q_o(m_q)
    );

    assign {bus.write_regM, bus.reg_writeM, bus.mem_to_regM, bus.mem_writeM} = m_q;

    pipe_reg #(.WIDTH(7)) u_memwb (
        .clk(clk), .rst(reset), .en_i(1'b1), .clr_i(1'b0),
        .d_i({bus.write_regM, bus.reg_writeM, bus.mem_to_regM}), .q_o(w_q)
    );

    assign {bus.write_regW, bus.reg_writeW, bus.mem_to_regW} = w_q;

    always_comb begin
        stall_cnt_d = (bus.stallD && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (bus.pc_srcD && !bus.stallD && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// tb_pipe_ctrl_regs: directed hazard scenarios checked against a stage-record model every cycle
module tb_pipe_ctrl_regs;
    localparam int XLEN = 64;
    localparam int CNT_W = 4;
    localparam logic [31:0] NOP_I = 32'h0000_0013;
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic rw, mtr, mw;
    } stage_t;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_regs_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    pipe_ctrl_regs #(.XLEN(XLEN), .RESET_PC(64'h0), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Instruction memory: rd = word+4, rs1 = word+20, rs2 = word+10 (word = pc[5:2])
    function automatic logic [31:0] imem(logic [63:0] pc);
        return {7'd0, 5'(pc[5:2] + 4'd10), 5'(pc[5:2] + 5'd20), 3'd0, 5'(pc[5:2] + 4'd4), 7'h33};
    endfunction

    assign bus.instrF = imem(bus.pcF);

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    // Model: architectural view of each stage as a record, advanced once per edge
    logic [63:0] m_pc, m_pcd;
    logic [31:0] m_ins;
    stage_t m_e, m_m, m_w, zero_s;
    int m_sc, m_fc;
    bit started = 0;

    initial zero_s = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        stage_t ne;
        bit tk;
        started = 1;
        if (reset) begin
            m_pc = 64'h0; m_ins = NOP_I; m_pcd = 64'h0;
            m_e = zero_s; m_m = zero_s; m_w = zero_s;
            m_sc = 0; m_fc = 0;
        end else begin
            ne = bus.flushE ? zero_s :
                 '{m_ins[19:15], m_ins[24:20], m_ins[11:7], bus.reg_writeD, bus.mem_to_regD, bus.mem_writeD};
            m_w = m_m;
            m_m = m_e;
            m_e = ne;
            tk = bus.pc_srcD && !bus.stallF && !bus.stallD;
            if (!bus.stallD) begin
                m_ins = tk ? NOP_I : bus.instrF;
                m_pcd = tk ? 64'h0 : m_pc;
            end
            if (!bus.stallF) m_pc = tk ? bus.pc_branchD : m_pc + 64'd4;
            if (bus.stallD && m_sc < CMAX) m_sc++;
            if (bus.pc_srcD && !bus.stallD && m_fc < CMAX) m_fc++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pcF", bus.pcF, m_pc);
            chk("instrD", bus.instrD, m_ins);
            chk("pcD", bus.pcD, m_pcd);
            chk("rs1D", bus.rs1D, m_ins[19:15]);
            chk("rs2D", bus.rs2D, m_ins[24:20]);
            chk("rdD", bus.rdD, m_ins[11:7]);
            chk("rs1E", bus.rs1E, m_e.rs1);
            chk("rs2E", bus.rs2E, m_e.rs2);
            chk("rdE", bus.rdE, m_e.rd);
            chk("ctlE", {bus.reg_writeE, bus.mem_to_regE, bus.mem_writeE}, {m_e.rw, m_e.mtr, m_e.mw});
            chk("write_regM", bus.write_regM, m_m.rd);
            chk("ctlM", {bus.reg_writeM, bus.mem_to_regM, bus.mem_writeM}, {m_m.rw, m_m.mtr, m_m.mw});
            chk("write_regW", bus.write_regW, m_w.rd);
            chk("ctlW", {bus.reg_writeW, bus.mem_to_regW}, {m_w.rw, m_w.mtr});
            chk("stall_cnt", bus.stall_cnt, m_sc);
            chk("flush_cnt", bus.flush_cnt, m_fc);
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hz(logic sf, logic sd, logic fe, logic br, logic [63:0] tgt);
        bus.stallF = sf; bus.stallD = sd; bus.flushE = fe; bus.pc_srcD = br; bus.pc_branchD = tgt;
    endtask

    initial begin
        reset = 1'b1;
        hz(1, 0, 1, 0, 64'h0);
        bus.reg_writeD = 0; bus.mem_to_regD = 0; bus.mem_writeD = 0;
        step(2);
        chk("rst_pcF", bus.pcF, 64'h0);
        chk("rst_instrD", bus.instrD, 32'h0000_0013);
        chk("rst_rdE", bus.rdE, 5'd0);
        chk("rst_cnt", {bus.stall_cnt, bus.flush_cnt}, 8'h00);
        reset = 1'b0;
        hz(0, 0, 0, 0, 64'h0);
        step(1);
        chk("pc_step1", bus.pcF, 64'h4);
        step(1);
        chk("pc_step2", bus.pcF, 64'h8);
        chk("rdD_pc4", bus.rdD, 5'd5);
        bus.reg_writeD = 1; bus.mem_to_regD = 1;
        step(1);
        chk("lu_rdE", bus.rdE, 5'd5);
        chk("lu_mtrE", bus.mem_to_regE, 1'b1);
        bus.reg_writeD = 0; bus.mem_to_regD = 0;
        hz(1, 1, 1, 0, 64'h0);
        step(1);
        chk("lu_pc_hold", bus.pcF, 64'hc);
        chk("lu_rdD_hold", bus.rdD, 5'd6);
        chk("lu_bubble", {bus.rdE, bus.reg_writeE}, 6'd0);
        chk("lu_stall_cnt", bus.stall_cnt, 4'd1);
        chk("lu_regM", bus.write_regM, 5'd5);
        hz(0, 0, 0, 0, 64'h0);
        bus.reg_writeD = 1;
        step(1);
        chk("lu_reenter", bus.rdE, 5'd6);
        step(1);
        chk("prop_E", {bus.rdE, bus.reg_writeE}, {5'd7, 1'b1});
        step(1);
        chk("prop_M", bus.write_regM, 5'd7);
        step(1);
        chk("prop_W", {bus.write_regW, bus.reg_writeW}, {5'd7, 1'b1});
        bus.reg_writeD = 0;
        hz(0, 0, 0, 1, 64'h100);
        step(1);
        chk("br_pcF", bus.pcF, 64'h100);
        chk("br_instrD", bus.instrD, 32'h0000_0013);
        chk("br_flush_cnt", bus.flush_cnt, 4'd1);
        hz(0, 0, 0, 0, 64'h0);
        step(1);
        hz(1, 1, 0, 1, 64'h200);
        step(1);
        chk("brst_pcF", bus.pcF, 64'h104);
        chk("brst_instrD", bus.instrD, imem(64'h100));
        chk("brst_flush_cnt", bus.flush_cnt, 4'd1);
        hz(1, 1, 0, 0, 64'h0);
        step(20);
        chk("sat_stall", bus.stall_cnt, 4'd15);
        hz(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        chk("wrap_top", bus.pcF, 64'hFFFF_FFFF_FFFF_FFFC);
        hz(0, 0, 0, 0, 64'h0);
        step(1);
        chk("wrap_zero", bus.pcF, 64'h0);
        hz(0, 0, 0, 1, 64'h40);
        step(16);
        chk("sat_flush", bus.flush_cnt, 4'd15);
        chk("sat_flush_pc", bus.pcF, 64'h40);
        reset = 1'b1;
        hz(1, 1, 1, 1, 64'h80);
        step(1);
        chk("mid_rst", {bus.pcF, bus.stall_cnt, bus.flush_cnt}, 72'h0);
        chk("mid_rst_instrD", bus.instrD, 32'h0000_0013);
        reset = 1'b0;
        hz(0, 0, 0, 0, 64'h0);
        step(1);
        chk("post_rst_pc", bus.pcF, 64'h4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
